// File: rtl/miner_pkg.sv
// Shared types and sizes for the mining datapath: scheduler, preprocessor and hash core.
package miner_pkg;

    localparam int MESSAGE_SIZE_DEF = 640;
    localparam int NONCE_WIDTH_DEF  = 32;
    localparam int DIGEST_WIDTH     = 256;
    localparam int ATTEMPT_WIDTH    = 32;
    localparam int SLICE_WIDTH      = 64;
    localparam int SLICE_COUNT      = DIGEST_WIDTH / SLICE_WIDTH;

    localparam logic [ATTEMPT_WIDTH-1:0] ATTEMPT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRE_START  = 3'd1,
        ST_PRE_WAIT   = 3'd2,
        ST_HASH_START = 3'd3,
        ST_HASH_WAIT  = 3'd4,
        ST_COMPARE    = 3'd5,
        ST_DRAIN      = 3'd6
    } state_e;

    function automatic logic [ATTEMPT_WIDTH-1:0] sat_inc(input logic [ATTEMPT_WIDTH-1:0] v);
        return (v == ATTEMPT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/nonce_scheduler_if.sv
// Job, preprocessor and hash-core signals of the nonce scheduler, bundled for one port.
interface nonce_scheduler_if
    import miner_pkg::*;
#(
    parameter int MESSAGE_SIZE = MESSAGE_SIZE_DEF,
    parameter int NONCE_WIDTH  = NONCE_WIDTH_DEF
) ();

    // Every handshake here is a single-cycle pulse with no back-pressure: start/abort from
    // the host, pre_begin/hash_start out to the datapath, pre_done/hash_done back; a pulse
    // is acted on only in the state that expects it and is otherwise dropped.
    logic                                  start;
    logic                                  abort;
    logic [MESSAGE_SIZE-NONCE_WIDTH-1:0]   header_in;
    logic [NONCE_WIDTH-1:0]                nonce_first;
    logic [NONCE_WIDTH-1:0]                nonce_last;
    logic [DIGEST_WIDTH-1:0]               target;

    logic                                  pre_begin;
    logic [MESSAGE_SIZE-1:0]               pre_msg;
    logic                                  pre_done;
    logic                                  hash_start;
    logic                                  hash_done;
    logic [DIGEST_WIDTH-1:0]               hash_in;

    logic                                  busy;
    logic                                  found;
    logic                                  exhausted;
    logic [NONCE_WIDTH-1:0]                nonce_out;
    logic [ATTEMPT_WIDTH-1:0]              attempts;
    state_e                                dbg_state;

    modport master (
        input  start, abort, header_in, nonce_first, nonce_last, target,
        input  pre_done, hash_done, hash_in,
        output pre_begin, pre_msg, hash_start,
        output busy, found, exhausted, nonce_out, attempts, dbg_state
    );

    modport slave (
        output start, abort, header_in, nonce_first, nonce_last, target,
        output pre_done, hash_done, hash_in,
        input  pre_begin, pre_msg, hash_start,
        input  busy, found, exhausted, nonce_out, attempts, dbg_state
    );

endinterface

// File: rtl/digest_compare.sv
// Registered unsigned digest < target, evaluated as four 64-bit slices from the top down.
module digest_compare
    import miner_pkg::*;
(
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    en_i,
    input  logic [DIGEST_WIDTH-1:0] a_i,
    input  logic [DIGEST_WIDTH-1:0] b_i,
    output logic                    lt_o
);

    logic [SLICE_COUNT-1:0] slice_lt;
    logic [SLICE_COUNT-1:0] slice_eq;
    logic                   lt_d;
    logic                   lt_q;

    for (genvar g = 0; g < SLICE_COUNT; g++) begin : g_slice
        assign slice_lt[g] = a_i[g*SLICE_WIDTH +: SLICE_WIDTH] <  b_i[g*SLICE_WIDTH +: SLICE_WIDTH];
        assign slice_eq[g] = a_i[g*SLICE_WIDTH +: SLICE_WIDTH] == b_i[g*SLICE_WIDTH +: SLICE_WIDTH];
    end

    // The most significant unequal slice decides; all-equal means not less.
    always_comb begin
        lt_d = 1'b0;
        for (int i = 0; i < SLICE_COUNT; i++) begin
            if (slice_lt[i]) lt_d = 1'b1;
            else if (!slice_eq[i]) lt_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lt_q <= 1'b0;
        end else if (en_i) begin
            lt_q <= lt_d;
        end
    end

    assign lt_o = lt_q;

endmodule

// File: rtl/nonce_scheduler.sv
// Runs one mining job: walks the nonce range, launching preprocessor and hash core per nonce.
module nonce_scheduler
    import miner_pkg::*;
#(
    parameter int MESSAGE_SIZE = MESSAGE_SIZE_DEF,
    parameter int NONCE_WIDTH  = NONCE_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    nonce_scheduler_if.master bus
);

    localparam int HEADER_W = MESSAGE_SIZE - NONCE_WIDTH;

    state_e                    state_q;
    logic [HEADER_W-1:0]       header_q;
    logic [NONCE_WIDTH-1:0]    nonce_q;
    logic [NONCE_WIDTH-1:0]    last_q;
    logic [DIGEST_WIDTH-1:0]   target_q;
    logic                      found_q;
    logic                      exhausted_q;
    logic [ATTEMPT_WIDTH-1:0]  attempts_q;
    logic                      pre_begin_q;
    logic                      hash_start_q;
    logic                      drain_hash_q;
    logic                      hash_accept;
    logic                      hit;

    assign hash_accept = (state_q == ST_HASH_WAIT) && bus.hash_done && !bus.abort;

    digest_compare u_digest_compare (
        .clk   (clk),
        .n_rst (n_rst),
        .en_i  (hash_accept),
        .a_i   (bus.hash_in),
        .b_i   (target_q),
        .lt_o  (hit)
    );

    // drain_hash_q records which completion pulse DRAIN is waiting for.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            header_q     <= '0;
            nonce_q      <= '0;
            last_q       <= '0;
            target_q     <= '0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            attempts_q   <= '0;
            pre_begin_q  <= 1'b0;
            hash_start_q <= 1'b0;
            drain_hash_q <= 1'b0;
        end else begin
            pre_begin_q  <= 1'b0;
            hash_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        header_q    <= bus.header_in;
                        nonce_q     <= bus.nonce_first;
                        last_q      <= bus.nonce_last;
                        target_q    <= bus.target;
                        found_q     <= 1'b0;
                        exhausted_q <= 1'b0;
                        attempts_q  <= '0;
                        pre_begin_q <= 1'b1;
                        state_q     <= ST_PRE_START;
                    end
                end
                ST_PRE_START: begin
                    if (bus.abort) begin
                        drain_hash_q <= 1'b0;
                        state_q      <= ST_DRAIN;
                    end else begin
                        state_q <= ST_PRE_WAIT;
                    end
                end
                ST_PRE_WAIT: begin
                    if (bus.abort) begin
                        drain_hash_q <= 1'b0;
                        state_q      <= bus.pre_done ? ST_IDLE : ST_DRAIN;
                    end else if (bus.pre_done) begin
                        hash_start_q <= 1'b1;
                        state_q      <= ST_HASH_START;
                    end
                end
                ST_HASH_START: begin
                    if (bus.abort) begin
                        drain_hash_q <= 1'b1;
                        state_q      <= ST_DRAIN;
                    end else begin
                        state_q <= ST_HASH_WAIT;
                    end
                end
                ST_HASH_WAIT: begin
                    if (bus.abort) begin
                        drain_hash_q <= 1'b1;
                        state_q      <= bus.hash_done ? ST_IDLE : ST_DRAIN;
                    end else if (bus.hash_done) begin
                        state_q <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (bus.abort) begin
                        state_q <= ST_IDLE;
                    end else begin
                        attempts_q <= sat_inc(attempts_q);
                        if (hit) begin
                            found_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (nonce_q == last_q) begin
                            exhausted_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            nonce_q     <= nonce_q + 1'b1;
                            pre_begin_q <= 1'b1;
                            state_q     <= ST_PRE_START;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_hash_q ? bus.hash_done : bus.pre_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.pre_begin  = pre_begin_q;
    assign bus.hash_start = hash_start_q;
    assign bus.pre_msg    = {header_q, nonce_q};
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.found      = found_q;
    assign bus.exhausted  = exhausted_q;
    assign bus.nonce_out  = nonce_q;
    assign bus.attempts   = attempts_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Bench for nonce_scheduler: latency models for the datapath plus a nonce scoreboard.
module tb_nonce_scheduler;
  import miner_pkg::*;

  localparam int MS = 640;
  localparam int NW = 32;
  localparam int HW = MS - NW;
  localparam int DW = 256;
  localparam int PRE_LAT = 3;
  localparam int HASH_LAT = 5;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  nonce_scheduler_if #(.MESSAGE_SIZE(MS), .NONCE_WIDTH(NW)) bus ();

  nonce_scheduler #(.MESSAGE_SIZE(MS), .NONCE_WIDTH(NW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.master)
  );

  int tests = 0;
  int fails = 0;
  logic [NW-1:0] exp_q[$];
  logic [HW-1:0] cur_header;
  int n_pre = 0;
  int n_hash = 0;

  bit model_en = 1'b1;
  int pre_cnt = 0;
  int hash_cnt = 0;
  logic model_pre_done = 1'b0;
  logic model_hash_done = 1'b0;
  logic man_pre_done = 1'b0;
  logic man_hash_done = 1'b0;
  logic [NW-1:0] hash_nonce = '0;
  bit hit_en = 1'b0;
  logic [NW-1:0] hit_nonce = '0;
  logic [DW-1:0] hit_digest = '0;

  assign bus.pre_done = model_pre_done | man_pre_done;
  assign bus.hash_done = model_hash_done | man_hash_done;
  assign bus.hash_in = (hit_en && hash_nonce == hit_nonce) ? hit_digest : {DW{1'b1}};

  // datapath latency models
  initial begin
    forever begin
      @(negedge clk);
      model_pre_done = 1'b0;
      model_hash_done = 1'b0;
      if (pre_cnt > 0) begin
        pre_cnt--;
        if (pre_cnt == 0) model_pre_done = 1'b1;
      end
      if (hash_cnt > 0) begin
        hash_cnt--;
        if (hash_cnt == 0) model_hash_done = 1'b1;
      end
      if (bus.pre_begin && model_en) pre_cnt = PRE_LAT;
      if (bus.hash_start) begin
        hash_nonce = bus.pre_msg[NW-1:0];
        if (model_en) hash_cnt = HASH_LAT;
      end
    end
  end

  // scoreboard: every pre_begin pops the next expected nonce; pre_msg must hold until pre_done
  logic [MS-1:0] win_msg;
  bit win = 1'b0;
  bit stab_bad = 1'b0;
  initial begin
    logic [NW-1:0] exp_n;
    forever begin
      @(posedge clk);
      #1;
      if (!n_rst) begin
        win = 1'b0;
      end else begin
        if (win && bus.pre_msg !== win_msg) stab_bad = 1'b1;
        if (win && bus.pre_done) begin
          tests++;
          if (stab_bad) begin
            fails++;
            $display("FAIL pre_msg_stable: pre_msg=%h changed, required %h", bus.pre_msg, win_msg);
          end
          win = 1'b0;
        end
        if (bus.pre_begin) begin
          n_pre++;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_nonce: unexpected pre_begin with nonce %h, required none", bus.pre_msg[NW-1:0]);
          end else begin
            exp_n = exp_q.pop_front();
            if (bus.pre_msg[NW-1:0] !== exp_n) begin
              fails++;
              $display("FAIL sb_nonce: got %h, required %h", bus.pre_msg[NW-1:0], exp_n);
            end
          end
          tests++;
          if (bus.pre_msg[MS-1:NW] !== cur_header) begin
            fails++;
            $display("FAIL sb_header: pre_msg header differs from latched header");
          end
          win = 1'b1;
          win_msg = bus.pre_msg;
          stab_bad = 1'b0;
        end
        if (bus.hash_start) n_hash++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [HW-1:0] rand_header();
    logic [HW-1:0] h;
    for (int i = 0; i < HW / 32; i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  task automatic start_job(input logic [NW-1:0] first, input logic [NW-1:0] last,
                           input logic [DW-1:0] tgt);
    cur_header = rand_header();
    bus.header_in = cur_header;
    bus.nonce_first = first;
    bus.nonce_last = last;
    bus.target = tgt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    int n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    timed_out = (bus.busy !== 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests += 9;
    if (bus.pre_begin !== 1'b0) begin fails++; $display("FAIL rst_pre_begin: got %b, required 0", bus.pre_begin); end
    if (bus.hash_start !== 1'b0) begin fails++; $display("FAIL rst_hash_start: got %b, required 0", bus.hash_start); end
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
    if (bus.found !== 1'b0) begin fails++; $display("FAIL rst_found: got %b, required 0", bus.found); end
    if (bus.exhausted !== 1'b0) begin fails++; $display("FAIL rst_exhausted: got %b, required 0", bus.exhausted); end
    if (bus.nonce_out !== '0) begin fails++; $display("FAIL rst_nonce: got %h, required 0", bus.nonce_out); end
    if (bus.attempts !== '0) begin fails++; $display("FAIL rst_attempts: got %0d, required 0", bus.attempts); end
    if (bus.pre_msg !== '0) begin fails++; $display("FAIL rst_pre_msg: got nonzero, required 0"); end
    if (bus.dbg_state !== ST_IDLE) begin fails++; $display("FAIL rst_state: got %0d, required %0d", bus.dbg_state, ST_IDLE); end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_job(input string tag, input bit exp_found, input bit exp_exh,
                           input logic [NW-1:0] exp_nonce, input int exp_att,
                           input int pre0, input int hash0, input int exp_pulses);
    bit to;
    wait_idle(400, to);
    tests += 7;
    if (to) begin fails++; $display("FAIL %s_timeout: busy=%b, required 0", tag, bus.busy); end
    if (bus.found !== exp_found) begin fails++; $display("FAIL %s_found: got %b, required %b", tag, bus.found, exp_found); end
    if (bus.exhausted !== exp_exh) begin fails++; $display("FAIL %s_exhausted: got %b, required %b", tag, bus.exhausted, exp_exh); end
    if (bus.nonce_out !== exp_nonce) begin fails++; $display("FAIL %s_nonce: got %h, required %h", tag, bus.nonce_out, exp_nonce); end
    if (bus.attempts !== exp_att) begin fails++; $display("FAIL %s_attempts: got %0d, required %0d", tag, bus.attempts, exp_att); end
    if (exp_q.size() != 0) begin fails++; $display("FAIL %s_queue: %0d nonces never issued, required 0", tag, exp_q.size()); end
    if (n_pre - pre0 != exp_pulses || n_hash - hash0 != exp_pulses) begin
      fails++;
      $display("FAIL %s_pulses: pre=%0d hash=%0d, required %0d each", tag, n_pre - pre0, n_hash - hash0, exp_pulses);
    end
  endtask

  task automatic test_hit_third();
    int p0 = n_pre, h0 = n_hash;
    hit_en = 1'b1; hit_nonce = 32'h12; hit_digest = 256'h1;
    for (int n = 'h10; n <= 'h12; n++) exp_q.push_back(NW'(n));
    start_job(32'h10, 32'h20, 256'h100);
    check_job("hit", 1'b1, 1'b0, 32'h12, 3, p0, h0, 3);
  endtask

  task automatic test_wrap_exhaust();
    int p0 = n_pre, h0 = n_hash;
    hit_en = 1'b0;
    exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    start_job(32'hFFFF_FFFE, 32'h0000_0001, {1'b1, 255'h0});
    check_job("wrap", 1'b0, 1'b1, 32'h1, 4, p0, h0, 4);
  endtask

  task automatic test_single();
    int p0 = n_pre, h0 = n_hash;
    hit_en = 1'b0;
    exp_q.push_back(32'h5);
    start_job(32'h5, 32'h5, 256'h0);
    check_job("single", 1'b0, 1'b1, 32'h5, 1, p0, h0, 1);
  endtask

  task automatic test_equal_boundary();
    logic [DW-1:0] tgt = {4{64'h0123_4567_89AB_CDEF}};
    int p0 = n_pre, h0 = n_hash;
    hit_en = 1'b1; hit_nonce = 32'h7; hit_digest = tgt;
    exp_q.push_back(32'h7);
    start_job(32'h7, 32'h7, tgt);
    check_job("eq", 1'b0, 1'b1, 32'h7, 1, p0, h0, 1);
    p0 = n_pre; h0 = n_hash;
    hit_digest = tgt - 1'b1;
    exp_q.push_back(32'h7);
    start_job(32'h7, 32'h7, tgt);
    check_job("below", 1'b1, 1'b0, 32'h7, 1, p0, h0, 1);
  endtask

  task automatic test_abort_hash_wait();
    int p0, h0;
    model_en = 1'b0; hit_en = 1'b0;
    p0 = n_pre; h0 = n_hash;
    exp_q.push_back(32'h30);
    start_job(32'h30, 32'h40, 256'h0);
    @(negedge clk);
    man_pre_done = 1'b1;
    @(negedge clk);
    man_pre_done = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.dbg_state !== ST_HASH_WAIT) begin fails++; $display("FAIL abort_hw_pre: state %0d, required %0d", bus.dbg_state, ST_HASH_WAIT); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.dbg_state !== ST_DRAIN || bus.busy !== 1'b1) begin
      fails++; $display("FAIL abort_hw_drain: state %0d busy %b, required %0d busy 1", bus.dbg_state, bus.busy, ST_DRAIN);
    end
    man_hash_done = 1'b1;
    @(negedge clk);
    man_hash_done = 1'b0;
    tests++;
    if (bus.dbg_state !== ST_IDLE || bus.busy !== 1'b0) begin
      fails++; $display("FAIL abort_hw_idle: state %0d busy %b, required %0d busy 0", bus.dbg_state, bus.busy, ST_IDLE);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (bus.found !== 1'b0 || bus.exhausted !== 1'b0 || n_pre - p0 != 1 || n_hash - h0 != 1) begin
      fails++; $display("FAIL abort_hw_after: found %b exh %b pre %0d hash %0d, required 0 0 1 1",
                        bus.found, bus.exhausted, n_pre - p0, n_hash - h0);
    end
  endtask

  task automatic test_abort_with_pre_done();
    int p0 = n_pre, h0 = n_hash;
    exp_q.push_back(32'h50);
    start_job(32'h50, 32'h58, 256'h0);
    @(negedge clk);
    man_pre_done = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    man_pre_done = 1'b0;
    bus.abort = 1'b0;
    tests++;
    if (bus.dbg_state !== ST_IDLE || bus.busy !== 1'b0) begin
      fails++; $display("FAIL abort_pd_idle: state %0d busy %b, required %0d busy 0", bus.dbg_state, bus.busy, ST_IDLE);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (n_hash - h0 != 0 || n_pre - p0 != 1 || bus.found !== 1'b0 || bus.exhausted !== 1'b0) begin
      fails++; $display("FAIL abort_pd_pulses: pre %0d hash %0d found %b exh %b, required 1 0 0 0",
                        n_pre - p0, n_hash - h0, bus.found, bus.exhausted);
    end
  endtask

  task automatic test_busy_start_spurious();
    exp_q.push_back(32'h60);
    exp_q.push_back(32'h61);
    start_job(32'h60, 32'h61, 256'h0);
    @(negedge clk);
    man_hash_done = 1'b1;
    bus.start = 1'b1;
    bus.nonce_first = 32'h99;
    bus.header_in = ~cur_header;
    @(negedge clk);
    man_hash_done = 1'b0;
    bus.start = 1'b0;
    tests++;
    if (bus.dbg_state !== ST_PRE_WAIT || bus.nonce_out !== 32'h60) begin
      fails++; $display("FAIL ignore_busy: state %0d nonce %h, required %0d nonce 60", bus.dbg_state, bus.nonce_out, ST_PRE_WAIT);
    end
    man_pre_done = 1'b1;
    @(negedge clk);
    man_pre_done = 1'b0;
    @(negedge clk);
    man_hash_done = 1'b1;
    @(negedge clk);
    man_hash_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (bus.dbg_state !== ST_PRE_WAIT || bus.attempts !== 1 || bus.nonce_out !== 32'h61) begin
      fails++; $display("FAIL next_nonce: state %0d att %0d nonce %h, required %0d 1 61",
                        bus.dbg_state, bus.attempts, bus.nonce_out, ST_PRE_WAIT);
    end
    #2;
    n_rst = 1'b0;
    #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.pre_begin !== 1'b0 || bus.hash_start !== 1'b0 || bus.found !== 1'b0 ||
        bus.exhausted !== 1'b0 || bus.nonce_out !== '0 || bus.attempts !== '0 || bus.pre_msg !== '0 ||
        bus.dbg_state !== ST_IDLE) begin
      fails++; $display("FAIL async_reset: busy %b nonce %h att %0d state %0d, required all 0",
                        bus.busy, bus.nonce_out, bus.attempts, bus.dbg_state);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.header_in = '0;
    bus.nonce_first = '0;
    bus.nonce_last = '0;
    bus.target = '0;
    test_reset();
    test_hit_third();
    test_wrap_exhaust();
    test_single();
    test_equal_boundary();
    test_abort_hash_wait();
    test_abort_with_pre_done();
    test_busy_start_spurious();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL final_queue: %0d entries left, required 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
